cos_req_arbiter: RTL

- Shares one cos(x) accelerator between NUM_REQ requesters using round-robin arbitration.
- Captures the winner's operand, launches the accelerator with a one-cycle start pulse, waits for the ready-low/ready-high sequence, then returns the result tagged with the requester id.
- Aborts and resets the accelerator if it stays busy longer than TIMEOUT cycles.
- Sits between the client blocks and the accelerator's start/ready/result interface.

---
 rtl/cos_arb_pkg.sv | 19 +
 rtl/cos_req_arbiter_rr_picker.sv | 32 +++
 rtl/cos_req_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cos_arb_pkg.sv
// Shared types and constants for the cos(x) accelerator request arbiter.
package cos_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LOW,
    WAIT_DONE,
    ABORT,
    DELIVER
  } state_t;

  localparam int WAIT_LOW_MAX = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cos_req_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted request at or after rr_ptr, wrapping.
module rr_picker
  import cos_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);

  always_comb begin
    logic           found;
    int             idx;
    logic [IDW-1:0] idx_c;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_c = IDW'(idx);
      if (!found && req[idx_c]) begin
        found  = 1'b1;
        winner = idx_c;
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/cos_req_arbiter.sv
// Round-robin arbiter sharing one cos(x) accelerator between NUM_REQ clients,
// with launch / ready-handshake / timeout-abort sequencing and tagged result delivery.
module cos_req_arbiter
  import cos_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int XW      = 16,
  parameter  int RW      = 16,
  parameter  int TIMEOUT = 255,
  localparam int IDW     = id_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*XW-1:0] x_in,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [RW-1:0]         res_data,
  output logic                  res_err,
  input  logic                  res_accept,
  output logic                  busy,
  output logic                  acc_start,
  output logic [XW-1:0]         acc_x,
  input  logic                  acc_ready,
  input  logic [RW-1:0]         acc_result,
  output logic                  acc_rst
);

  // state     | meaning
  // IDLE      | waiting for a request while the accelerator is ready
  // LAUNCH    | operand latched, start pulse issued on exit
  // WAIT_LOW  | waiting for the accelerator to drop ready
  // WAIT_DONE | accelerator running, timeout counter active
  // ABORT     | accelerator held in reset for one cycle
  // DELIVER   | result presented until accepted

  localparam logic [15:0]    TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [1:0]     WL_LAST = 2'(WAIT_LOW_MAX);

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_id;
  logic           any_req;
  logic [1:0]     wl_cnt;
  logic [15:0]    to_cnt;
  logic [XW-1:0]  x_sel;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (win_id),
    .any_req(any_req)
  );

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == IDW'(i)) x_sel = x_in[i*XW +: XW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Completion is tested before the timeout so a simultaneous finish is delivered normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any_req && acc_ready) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!acc_ready)             state_d = WAIT_DONE;
        else if (wl_cnt == WL_LAST) state_d = ABORT;
      end
      WAIT_DONE: begin
        if (acc_ready)              state_d = DELIVER;
        else if (to_cnt == TO_LAST) state_d = ABORT;
      end
      ABORT:     state_d = DELIVER;
      DELIVER:   if (res_accept) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered; acc_start follows LAUNCH by one cycle so it trails gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      acc_start <= 1'b0;
      acc_x     <= '0;
      acc_rst   <= 1'b0;
      rr_ptr    <= '0;
      wl_cnt    <= '0;
      to_cnt    <= '0;
    end else begin
      gnt       <= '0;
      acc_start <= (state_q == LAUNCH);
      acc_rst   <= (state_d == ABORT);
      busy      <= (state_d != IDLE);
      res_valid <= (state_d == DELIVER);
      case (state_q)
        IDLE: begin
          if (state_d == LAUNCH) begin
            gnt[win_id] <= 1'b1;
            res_id      <= win_id;
            acc_x       <= x_sel;
          end
        end
        LAUNCH:   wl_cnt <= '0;
        WAIT_LOW: wl_cnt <= wl_cnt + 2'd1;
        WAIT_DONE: begin
          to_cnt <= to_cnt + 16'd1;
          if (acc_ready) begin
            res_data <= acc_result;
            res_err  <= 1'b0;
          end
        end
        ABORT: begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
        DELIVER: begin
          if (res_accept) begin
            rr_ptr <= (res_id == LAST_ID) ? '0 : res_id + 1'b1;
            to_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
